mont_reduce16: RTL
==================

# mont_reduce16

- Word-level Montgomery reduction stage for the 16-bit modified Montgomery multiplier datapath.
- Sits directly downstream of the registered 16x16 Karatsuba product stage and consumes its 32-bit product T.
- Returns u = T·R⁻¹ mod n, with R = 2^16, using a valid/ready handshake.
- Internally runs a small FSM that time-shares one 16x16 multiplier for the m and m·n products.

## Interface
- `W`, default 16: operand/modulus width. R = 2^W. Only 16 is supported.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: T, n and n_prime are valid.
- `in_ready`, output, 1: stage can accept; equals (state == IDLE).
- `t_in`, input, 2W: product T from the multiplier. Precondition: T < n·R.
- `n`, input, W: modulus. Must be odd.
- `n_prime`, input, W: −n⁻¹ mod R.
- `out_valid`, output, 1: r_out is valid.
- `out_ready`, input, 1: consumer accepts r_out.
- `r_out`, output, W+1: reduced result.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. On that edge t_in, n and n_prime are captured into internal registers; later input changes are ignored.
- FSM states: IDLE → MUL_M → MUL_MN → ADD → SUB → DONE → IDLE.
- IDLE: waits for a transfer in.
- MUL_M: m ← (T[W-1:0] · n') mod R. Truncate to W bits.
- MUL_MN: mn ← m · n, 2W bits. Uses the same shared multiplier instance.
- ADD: s = T + mn, 2W+1 bits, carry kept. u ← s[2W:W], W+1 bits. s[W-1:0] is zero by construction and is discarded.
- SUB: r ← (u ≥ n) ? u − n : u. Comparison is on the W+1-bit u against the zero-extended n.
- DONE: out_valid = 1 and r_out is held stable. The FSM moves to IDLE on out_valid && out_ready.
- No overlap: in_ready = 0 in every state except IDLE, so only one operation is in flight.
- Preconditions are not checked. If T ≥ n·R or n is even, the output is unspecified but the FSM still completes.
- Reset at any point: FSM goes to IDLE asynchronously. All internal registers clear and any in-flight operation is dropped.
- Reset values: out_valid = 0, r_out = 0. in_ready = 1 while in IDLE, including during reset.

## Timing
- Edge E0 is the input transfer.
- E1 registers m, E2 registers mn, E3 registers u, E4 registers r and sets out_valid.
- Latency from transfer in to out_valid = 4 cycles with MONT_RED_FINAL_SUB_EN defined, 3 cycles without.
- Output transfer at edge Ek puts the FSM in IDLE after Ek, so in_ready = 1 in the next cycle.
- Back-to-back throughput is one result per 6 cycles (with final subtract) when out_ready is held high.
- out_ready low: out_valid and r_out stay constant for any number of cycles.
- out_ready is ignored outside DONE.

## Configuration
- Macro: `MONT_RED_FINAL_SUB_EN`.
- Defined: SUB state is present and r_out < n is guaranteed (r_out[W] = 0).
- Not defined: SUB state is omitted. ADD goes straight to DONE and r_out = u < 2n (lazy reduction, W+1 bits). This is for chaining into a next multiply that tolerates a [0, 2n) input. Latency is 3.

## Structure
- Shared package `mont_pkg`: W and R_BITS constants, and the FSM state encoding (IDLE=0, MUL_M=1, MUL_MN=2, ADD=3, SUB=4, DONE=5, 3 bits).
- One sub-module, `mont_red_mul16`: combinational unsigned 16x16 → 32 multiplier. Its operands are muxed by state: (T_lo, n') in MUL_M, (m, n) in MUL_MN.

## Test plan
All cases use n = 0xFFF1 and n_prime = 0xEEEF.
- Reset mid-operation: assert rst_n = 0 during MUL_MN.
  - Immediately out_valid = 0, r_out = 0 and state is IDLE.
  - After release, in_ready = 1 and a new transfer completes normally.
- T = 0x0001_0000 → r_out = 0x0001, no subtract.
- T = 0x0000_0001 → r_out = 0xEEE1 (R⁻¹ mod n), latency exactly 4 cycles.
- T = 0xFFF0_FFFF, internal u = 0x11101:
  - With the macro: r_out = 0x1110.
  - Without the macro: r_out = 0x11101, latency 3.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE.
  - r_out and out_valid stay stable and in_ready = 0.
  - Toggling t_in during this period has no effect.
- Back-to-back: in_valid held high with T = 0 then T = 0x0001_0000, out_ready = 1.
  - Results are 0x0000 then 0x0001.
  - The second transfer is accepted exactly one cycle after the first output transfer.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared constants and FSM state encoding for the 16-bit Montgomery reduction datapath.
package mont_pkg;

   localparam int unsigned W      = 16;
   localparam int unsigned R_BITS = W;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StMulM  = 3'd1;
   localparam logic [2:0] StMulMn = 3'd2;
   localparam logic [2:0] StAdd   = 3'd3;
   localparam logic [2:0] StSub   = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

endpackage

// File: rtl/mont_red_mul16.sv
// Combinational unsigned W x W -> 2W multiplier shared by the m and m*n steps.
module mont_red_mul16 #(
   parameter int unsigned W = mont_pkg::W
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   always_comb begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   end

endmodule

// File: rtl/mont_reduce16.sv
// Word-level Montgomery reduction u = T * R^-1 mod n with a valid/ready handshake.
// Define MONT_RED_FINAL_SUB_EN to add the final conditional subtract (r_out < n).
module mont_reduce16 #(
   parameter int unsigned W = mont_pkg::W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] t_in,
   input  logic [W-1:0]   n,
   input  logic [W-1:0]   n_prime,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W:0]     r_out
);
   import mont_pkg::*;

   logic [2:0]     state_q, state_d;
   logic [2*W-1:0] t_q;
   logic [W-1:0]   n_q;
   logic [W-1:0]   np_q;
   logic [W-1:0]   m_q;
   logic [2*W-1:0] mn_q;
   logic [W:0]     r_q;
`ifdef MONT_RED_FINAL_SUB_EN
   logic [W:0]     u_q;
`endif

   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_p;
   logic [2*W:0]   sum;
   logic [W:0]     u_sum;
   logic           unused_sum_lo;

   // One multiplier, operands steered by the current step.
   always_comb begin
      mul_a = m_q;
      mul_b = n_q;
      if (state_q == StMulM) begin
         mul_a = t_q[W-1:0];
         mul_b = np_q;
      end
   end

   mont_red_mul16 #(
      .W (W)
   ) u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // Low half of T + m*n is zero by construction, so only the upper W+1 bits matter.
   always_comb begin
      sum           = {1'b0, t_q} + {1'b0, mn_q};
      u_sum         = sum[2*W:W];
      unused_sum_lo = ^sum[W-1:0];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = StMulM;
         StMulM:  state_d = StMulMn;
         StMulMn: state_d = StAdd;
`ifdef MONT_RED_FINAL_SUB_EN
         StAdd:   state_d = StSub;
         StSub:   state_d = StDone;
`else
         StAdd:   state_d = StDone;
`endif
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         t_q     <= '0;
         n_q     <= '0;
         np_q    <= '0;
         m_q     <= '0;
         mn_q    <= '0;
         r_q     <= '0;
`ifdef MONT_RED_FINAL_SUB_EN
         u_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  t_q  <= t_in;
                  n_q  <= n;
                  np_q <= n_prime;
               end
            end
            StMulM:  m_q  <= mul_p[W-1:0];
            StMulMn: mn_q <= mul_p;
`ifdef MONT_RED_FINAL_SUB_EN
            StAdd:   u_q  <= u_sum;
            StSub:   r_q  <= (u_q >= {1'b0, n_q}) ? (u_q - {1'b0, n_q}) : u_q;
`else
            StAdd:   r_q  <= u_sum;
`endif
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign r_out     = r_q;

endmodule
